// File: rtl/mem2io_ctrl.sv
// CPU <-> SRAM / memory-mapped IO bridge with a request/ready handshake,
// configurable SRAM wait states, a 2-flop switch synchroniser and LED/hex registers.
module mem2io_ctrl #(
   parameter int DATA_W      = 16,
   parameter int ADDR_W      = 16,
   parameter int SW_W        = 10,
   parameter int LED_W       = 10,
   parameter int NUM_HEX     = 4,
   parameter int WAIT_STATES = 1,
   parameter logic [ADDR_W-1:0] SW_HEX_ADDR = 16'hFFFF,
   parameter logic [ADDR_W-1:0] LED_ADDR    = 16'hFFFE
) (
   input  logic                   Clk,
   input  logic                   Reset,
   input  logic                   cpu_req,
   input  logic                   cpu_we,
   input  logic [ADDR_W-1:0]      cpu_addr,
   input  logic [DATA_W-1:0]      cpu_wdata,
   output logic [DATA_W-1:0]      cpu_rdata,
   output logic                   cpu_ready,
   input  logic [SW_W-1:0]        SW,
   output logic [LED_W-1:0]       LED,
   output logic [4*NUM_HEX-1:0]   hex_digits,
   output logic [ADDR_W-1:0]      sram_addr,
   output logic [DATA_W-1:0]      sram_wdata,
   input  logic [DATA_W-1:0]      Data_from_SRAM,
   output logic                   sram_oe_n,
   output logic                   sram_we_n
);

   localparam int HEX_W = 4 * NUM_HEX;
   localparam int CNT_W = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;

   typedef enum logic [1:0] {IDLE, SRAM_ACC, IO_DONE, SRAM_DONE} state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [ADDR_W-1:0]  addr_q, addr_d;
   logic [DATA_W-1:0]  wdata_q, wdata_d;
   logic               we_q, we_d;
   logic [DATA_W-1:0]  rdata_q, rdata_d;
   logic [LED_W-1:0]   led_q, led_d;
   logic [HEX_W-1:0]   hex_q, hex_d;
   logic [SW_W-1:0]    sw_meta_q, sw_sync_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      we_d    = we_q;
      rdata_d = rdata_q;
      led_d   = led_q;
      hex_d   = hex_q;
      case (state_q)
         IDLE: begin
            if (cpu_req) begin
               addr_d  = cpu_addr;
               we_d    = cpu_we;
               wdata_d = cpu_wdata;
               cnt_d   = '0;
               // Exact-match decode; every other address, even neighbours, is SRAM.
               if (cpu_addr == SW_HEX_ADDR || cpu_addr == LED_ADDR) begin
                  state_d = IO_DONE;
                  if (cpu_we) begin
                     if (cpu_addr == SW_HEX_ADDR) hex_d = cpu_wdata[HEX_W-1:0];
                     else                         led_d = cpu_wdata[LED_W-1:0];
                  end else begin
                     if (cpu_addr == SW_HEX_ADDR) rdata_d = DATA_W'(sw_sync_q);
                     else                         rdata_d = DATA_W'(led_q);
                  end
               end else begin
                  state_d = SRAM_ACC;
               end
            end
         end
         SRAM_ACC: begin
            if (cnt_q == CNT_W'(WAIT_STATES)) begin
               if (!we_q) rdata_d = Data_from_SRAM;
               state_d = SRAM_DONE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         IO_DONE:   state_d = IDLE;
         SRAM_DONE: state_d = IDLE;
         default:   state_d = IDLE;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         addr_q    <= '0;
         wdata_q   <= '0;
         we_q      <= 1'b0;
         rdata_q   <= '0;
         led_q     <= '0;
         hex_q     <= '0;
         sw_meta_q <= '0;
         sw_sync_q <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         we_q      <= we_d;
         rdata_q   <= rdata_d;
         led_q     <= led_d;
         hex_q     <= hex_d;
         sw_meta_q <= SW;
         sw_sync_q <= sw_meta_q;
      end
   end

   // Strobes decode from state only, so they can never both be low.
   assign sram_oe_n  = !(state_q == SRAM_ACC && !we_q);
   assign sram_we_n  = !(state_q == SRAM_ACC && we_q);
   assign cpu_ready  = (state_q == IO_DONE) || (state_q == SRAM_DONE);
   assign cpu_rdata  = rdata_q;
   assign LED        = led_q;
   assign hex_digits = hex_q;
   assign sram_addr  = addr_q;
   assign sram_wdata = wdata_q;

endmodule

// File: tb/tb_mem2io_ctrl.sv
// Bench for mem2io_ctrl: three instances with WAIT_STATES = 0/1/2, a transaction-level
// model checked every cycle, and directed accesses with literal expectations.
module tb_mem2io_ctrl;

   localparam int N = 3;   // instance k has WAIT_STATES = k

   logic        Clk = 1'b0;
   logic        Reset;
   logic [9:0]  SW;
   logic        req [N];
   logic        we [N];
   logic [15:0] addr [N];
   logic [15:0] wdata [N];
   logic [15:0] rdata [N];
   logic        ready [N];
   logic [9:0]  led [N];
   logic [15:0] hex [N];
   logic [15:0] saddr [N];
   logic [15:0] swdata [N];
   logic [15:0] dsram [N];
   logic        oe_n [N];
   logic        we_n [N];

   always #5 Clk = ~Clk;

   for (genvar gi = 0; gi < N; gi++) begin : g_dut
      mem2io_ctrl #(.WAIT_STATES(gi)) u_dut (
         .Clk(Clk), .Reset(Reset),
         .cpu_req(req[gi]), .cpu_we(we[gi]), .cpu_addr(addr[gi]), .cpu_wdata(wdata[gi]),
         .cpu_rdata(rdata[gi]), .cpu_ready(ready[gi]),
         .SW(SW), .LED(led[gi]), .hex_digits(hex[gi]),
         .sram_addr(saddr[gi]), .sram_wdata(swdata[gi]), .Data_from_SRAM(dsram[gi]),
         .sram_oe_n(oe_n[gi]), .sram_we_n(we_n[gi])
      );
   end

   // Behavioural SRAM per instance (low address byte only).
   logic [15:0] bmem [N][256];
   always @(posedge Clk)
      for (int k = 0; k < N; k++)
         if (!we_n[k]) bmem[k][saddr[k][7:0]] <= swdata[k];
   always_comb
      for (int k = 0; k < N; k++)
         dsram[k] = bmem[k][saddr[k][7:0]];

   int checks = 0;
   int passed = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask

   // Transaction model: phase counts cycles since acceptance, len is the ready cycle.
   bit          armed = 0;
   int          m_phase [N];
   int          m_len [N];
   bit          m_io [N];
   bit          m_we [N];
   logic [15:0] m_addr [N];
   logic [15:0] m_wdata [N];
   logic [15:0] m_rdata [N];
   logic [9:0]  m_led [N];
   logic [15:0] m_hex [N];
   logic [15:0] m_mem [N][256];
   logic [9:0]  sw_hist [2];   // SW as seen one and two edges ago

   task automatic model_step();
      logic [9:0] sw_seen;
      if (Reset) begin
         armed = 1;
         sw_hist[0] = '0;
         sw_hist[1] = '0;
         for (int k = 0; k < N; k++) begin
            m_phase[k] = 0; m_rdata[k] = '0; m_led[k] = '0; m_hex[k] = '0;
            m_addr[k] = '0; m_wdata[k] = '0; m_io[k] = 0; m_we[k] = 0;
         end
         return;
      end
      sw_seen    = sw_hist[1];
      sw_hist[1] = sw_hist[0];
      sw_hist[0] = SW;
      for (int k = 0; k < N; k++) begin
         if (m_phase[k] == 0) begin
            if (req[k]) begin
               m_addr[k]  = addr[k];
               m_wdata[k] = wdata[k];
               m_we[k]    = we[k];
               m_io[k]    = (addr[k] == 16'hFFFF) || (addr[k] == 16'hFFFE);
               m_phase[k] = 1;
               if (m_io[k]) begin
                  m_len[k] = 1;
                  if (we[k]) begin
                     if (addr[k] == 16'hFFFF) m_hex[k] = wdata[k];
                     else                     m_led[k] = wdata[k][9:0];
                  end else begin
                     m_rdata[k] = (addr[k] == 16'hFFFF) ? {6'b0, sw_seen} : {6'b0, m_led[k]};
                  end
               end else begin
                  m_len[k] = k + 2;
                  if (we[k]) m_mem[k][addr[k][7:0]] = wdata[k];
               end
            end
         end else begin
            if (!m_io[k] && !m_we[k] && m_phase[k] == k + 1)
               m_rdata[k] = m_mem[k][m_addr[k][7:0]];
            if (m_phase[k] == m_len[k]) m_phase[k] = 0;
            else                        m_phase[k] = m_phase[k] + 1;
         end
      end
   endtask

   initial forever begin
      @(posedge Clk);
      model_step();
   end

   // Per-cycle compare against the model.
   initial forever begin
      @(negedge Clk);
      if (armed) begin
         for (int k = 0; k < N; k++) begin
            bit acc;
            bit e_ready;
            e_ready = (m_phase[k] != 0) && (m_phase[k] == m_len[k]);
            acc     = (m_phase[k] != 0) && !m_io[k] && (m_phase[k] <= k + 1);
            chk($sformatf("ready[%0d]", k), ready[k], e_ready);
            chk($sformatf("oe_n[%0d]", k), oe_n[k], !(acc && !m_we[k]));
            chk($sformatf("we_n[%0d]", k), we_n[k], !(acc && m_we[k]));
            chk($sformatf("rdata[%0d]", k), rdata[k], m_rdata[k]);
            chk($sformatf("led[%0d]", k), led[k], m_led[k]);
            chk($sformatf("hex[%0d]", k), hex[k], m_hex[k]);
            if (acc) begin
               chk($sformatf("sram_addr[%0d]", k), saddr[k], m_addr[k]);
               chk($sformatf("sram_wdata[%0d]", k), swdata[k], m_wdata[k]);
            end
         end
      end
   end

   int          last_oe, last_we;
   logic [15:0] last_saddr, last_swdata;

   // One access from an idle cycle; counts cycles to ready (bounded) and strobe-low cycles.
   task automatic access(input int k, input bit w, input logic [15:0] a,
                         input logic [15:0] d, input int lat, input string nm);
      int n;
      @(negedge Clk);
      req[k] = 1'b1; we[k] = w; addr[k] = a; wdata[k] = d;
      n = 0; last_oe = 0; last_we = 0; last_saddr = '0; last_swdata = '0;
      do begin
         @(negedge Clk);
         req[k] = 1'b0;
         n++;
         if (!oe_n[k] || !we_n[k]) begin
            last_saddr  = saddr[k];
            last_swdata = swdata[k];
         end
         if (!oe_n[k]) last_oe++;
         if (!we_n[k]) last_we++;
      end while (!ready[k] && n < 12);
      chk({nm, " latency"}, n, lat);
      $display("txn %s inst=%0d we=%0d addr=%h wdata=%h cycles=%0d rdata=%h", nm, k, w, a, d, n, rdata[k]);
   endtask

   initial begin
      int pulses, p1, p2;
      Reset = 1'b1;
      SW = '0;
      for (int k = 0; k < N; k++) begin
         req[k] = 1'b0; we[k] = 1'b0; addr[k] = '0; wdata[k] = '0;
      end
      repeat (3) @(negedge Clk);
      chk("rst sram_addr", saddr[1], 16'h0000);
      chk("rst sram_wdata", swdata[1], 16'h0000);
      chk("rst rdata", rdata[1], 16'h0000);
      chk("rst oe_n", oe_n[1], 1'b1);
      chk("rst we_n", we_n[1], 1'b1);
      chk("rst ready", ready[1], 1'b0);
      Reset = 1'b0;
      repeat (3) @(negedge Clk);

      // IO writes and reads on the WAIT_STATES=1 instance
      access(1, 1'b1, 16'hFFFF, 16'h1234, 1, "hex_wr");
      chk("hex_wr value", hex[1], 16'h1234);
      chk("hex_wr ready", ready[1], 1'b1);
      @(negedge Clk);
      chk("hex_wr ready drop", ready[1], 1'b0);
      access(1, 1'b1, 16'hFFFE, 16'h03FF, 1, "led_wr");
      chk("led_wr value", led[1], 10'h3FF);
      @(negedge Clk);
      SW = 10'h2A5;
      repeat (3) @(negedge Clk);
      access(1, 1'b0, 16'hFFFF, 16'h0000, 1, "sw_rd");
      chk("sw_rd value", rdata[1], 16'h02A5);
      access(1, 1'b0, 16'hFFFE, 16'h0000, 1, "led_rd");
      chk("led_rd value", rdata[1], 16'h03FF);

      // SRAM accesses, WAIT_STATES=1
      access(1, 1'b1, 16'h0040, 16'hBEEF, 3, "sram_wr");
      chk("sram_wr we_n cycles", last_we, 2);
      chk("sram_wr oe_n cycles", last_oe, 0);
      chk("sram_wr addr", last_saddr, 16'h0040);
      chk("sram_wr data", last_swdata, 16'hBEEF);
      chk("sram_wr rdata kept", rdata[1], 16'h03FF);
      access(1, 1'b0, 16'h0040, 16'h0000, 3, "sram_rd");
      chk("sram_rd oe_n cycles", last_oe, 2);
      chk("sram_rd we_n cycles", last_we, 0);
      chk("sram_rd value", rdata[1], 16'hBEEF);

      // Neighbour of the IO addresses must go to SRAM
      access(1, 1'b1, 16'hFFFD, 16'h1111, 3, "adj_wr");
      chk("adj_wr hex kept", hex[1], 16'h1234);
      chk("adj_wr led kept", led[1], 10'h3FF);
      access(1, 1'b0, 16'hFFFD, 16'h0000, 3, "adj_rd");
      chk("adj_rd value", rdata[1], 16'h1111);

      // Back-to-back reads with cpu_req held high, WAIT_STATES=0
      access(0, 1'b1, 16'h0010, 16'hA5A5, 2, "w0_wr");
      @(negedge Clk);
      req[0] = 1'b1; we[0] = 1'b0; addr[0] = 16'h0010;
      pulses = 0; p1 = 0; p2 = 0;
      for (int i = 1; i <= 8; i++) begin
         @(negedge Clk);
         if (i == 4) req[0] = 1'b0;
         if (ready[0]) begin
            pulses++;
            if (pulses == 1) p1 = i;
            if (pulses == 2) p2 = i;
         end
      end
      chk("b2b pulses", pulses, 2);
      chk("b2b first ready", p1, 2);
      chk("b2b second ready", p2, 5);
      chk("b2b value", rdata[0], 16'hA5A5);
      $display("txn b2b inst=0 pulses=%0d at %0d,%0d rdata=%h", pulses, p1, p2, rdata[0]);

      // Reset in the second SRAM_ACC cycle of a write, WAIT_STATES=2
      @(negedge Clk);
      req[2] = 1'b1; we[2] = 1'b1; addr[2] = 16'h0020; wdata[2] = 16'h5555;
      @(negedge Clk);
      req[2] = 1'b0;
      @(negedge Clk);
      chk("abort we_n before reset", we_n[2], 1'b0);
      Reset = 1'b1;
      @(negedge Clk);
      chk("abort ready", ready[2], 1'b0);
      chk("abort we_n", we_n[2], 1'b1);
      chk("abort oe_n", oe_n[2], 1'b1);
      chk("abort led", led[2], 10'h000);
      chk("abort hex", hex[2], 16'h0000);
      Reset = 1'b0;
      pulses = 0;
      repeat (6) begin
         @(negedge Clk);
         if (ready[2]) pulses++;
      end
      chk("abort no pulse", pulses, 0);
      $display("txn abort inst=2 pulses_after=%0d", pulses);
      access(2, 1'b0, 16'h0020, 16'h0000, 4, "w2_rd");
      chk("w2_rd value", rdata[2], 16'h5555);

      repeat (2) @(negedge Clk);
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
